// File: rtl/writeback.sv
`default_nettype none
// ============================================================================
// Module   : writeback
// Purpose  : Final pipeline stage. Commits EX_WB results to the 32x32 register
//            file, serves the decode read ports, counts retirements and
//            implements HLT/resume. It also presents the last committed write
//            for forwarding.
// Option   : WB_BYPASS_EN - same-cycle write-to-read bypass on rs/rt ports
// Revision : 1.0 - initial release
// ============================================================================
module writeback #(
  parameter int          DATA_W = 32,
  parameter int          ADDR_W = 5,
  parameter int          BUS_W  = 181,
  parameter logic [15:0] HLT_OP = 16'hE,
  parameter logic [15:0] NOP_OP = 16'hF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [BUS_W-1:0]  EX_WB,
  input  logic              ex_valid,
  output logic              wb_ready,
  input  logic              resume,
  input  logic [ADDR_W-1:0] rs_addr,
  output logic [DATA_W-1:0] rs_data,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rt_data,
  output logic              fwd_valid,
  output logic [ADDR_W-1:0] fwd_addr,
  output logic [DATA_W-1:0] fwd_data,
  output logic              halted,
  output logic [31:0]       retire_count
);

  localparam int c_ADDR_LSB = 64;
  localparam int c_WE_BIT   = 69;
  localparam int c_OP_LSB   = 160;
  localparam int c_NREGS    = 2 ** ADDR_W;

  localparam logic [0:0] c_ST_RUN    = 1'b0;
  localparam logic [0:0] c_ST_HALTED = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [DATA_W-1:0] rf_q [c_NREGS];
  logic              fwd_valid_q, fwd_valid_d;
  logic [ADDR_W-1:0] fwd_addr_q, fwd_addr_d;
  logic [DATA_W-1:0] fwd_data_q, fwd_data_d;
  logic [31:0]       retire_q, retire_d;

  logic [DATA_W-1:0] w_data;
  logic [ADDR_W-1:0] w_addr;
  logic              w_we;
  logic [15:0]       w_op;
  logic              w_accept;
  logic              w_is_hlt;
  logic              w_is_nop;
  logic              w_do_write;
  logic              w_unused_bits;

  assign w_data = EX_WB[DATA_W-1:0];
  assign w_addr = EX_WB[c_ADDR_LSB +: ADDR_W];
  assign w_we   = EX_WB[c_WE_BIT];
  assign w_op   = EX_WB[c_OP_LSB +: 16];

  assign w_unused_bits = ^{EX_WB[BUS_W-1:c_OP_LSB+16], EX_WB[c_OP_LSB-1:c_WE_BIT+1],
                           EX_WB[c_ADDR_LSB-1:DATA_W]};

  assign wb_ready = (state_q == c_ST_RUN);
  assign halted   = (state_q == c_ST_HALTED);
  assign w_accept = ex_valid && wb_ready;
  assign w_is_hlt = (w_op == HLT_OP);
  assign w_is_nop = (w_op == NOP_OP);

  // Address 0 writes are dropped here so they never reach rf or fwd_*.
  assign w_do_write = w_accept && !w_is_hlt && !w_is_nop && w_we && (w_addr != '0);

  always_comb begin
    state_d = state_q;
    if (w_accept && w_is_hlt) begin
      state_d = c_ST_HALTED;
    end else if ((state_q == c_ST_HALTED) && resume) begin
      state_d = c_ST_RUN;
    end
  end

  always_comb begin
    retire_d    = retire_q;
    fwd_valid_d = w_do_write;
    fwd_addr_d  = fwd_addr_q;
    fwd_data_d  = fwd_data_q;
    if (w_accept) begin
      retire_d = retire_q + 32'd1;
    end
    if (w_do_write) begin
      fwd_addr_d = w_addr;
      fwd_data_d = w_data;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= c_ST_RUN;
      retire_q    <= '0;
      fwd_valid_q <= 1'b0;
      fwd_addr_q  <= '0;
      fwd_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      retire_q    <= retire_d;
      fwd_valid_q <= fwd_valid_d;
      fwd_addr_q  <= fwd_addr_d;
      fwd_data_q  <= fwd_data_d;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < c_NREGS; i++) begin
        rf_q[i] <= '0;
      end
    end else if (w_do_write) begin
      rf_q[w_addr] <= w_data;
    end
  end

  always_comb begin
    rs_data = (rs_addr == '0) ? '0 : rf_q[rs_addr];
    rt_data = (rt_addr == '0) ? '0 : rf_q[rt_addr];
`ifdef WB_BYPASS_EN
    if (w_do_write && (rs_addr == w_addr)) begin
      rs_data = w_data;
    end
    if (w_do_write && (rt_addr == w_addr)) begin
      rt_data = w_data;
    end
`else
    // Without bypass, decode picks up same-cycle writes through fwd_* next cycle.
`endif
  end

  assign fwd_valid    = fwd_valid_q;
  assign fwd_addr     = fwd_addr_q;
  assign fwd_data     = fwd_data_q;
  assign retire_count = retire_q;

endmodule
`default_nettype wire

// File: tb/tb_writeback.sv
`default_nettype none
// ============================================================================
// Module   : tb_writeback
// Purpose  : Scoreboard bench for writeback: driver pushes expected outputs,
//            monitor pops and compares after each clock edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_writeback;

  localparam logic [15:0] HLT = 16'hE;
  localparam logic [15:0] NOP = 16'hF;

  logic         clock;
  logic         reset;
  logic [180:0] EX_WB;
  logic         ex_valid;
  logic         wb_ready;
  logic         resume;
  logic [4:0]   rs_addr;
  logic [31:0]  rs_data;
  logic [4:0]   rt_addr;
  logic [31:0]  rt_data;
  logic         fwd_valid;
  logic [4:0]   fwd_addr;
  logic [31:0]  fwd_data;
  logic         halted;
  logic [31:0]  retire_count;

  writeback dut (
    .clock(clock), .reset(reset), .EX_WB(EX_WB), .ex_valid(ex_valid),
    .wb_ready(wb_ready), .resume(resume), .rs_addr(rs_addr), .rs_data(rs_data),
    .rt_addr(rt_addr), .rt_data(rt_data), .fwd_valid(fwd_valid),
    .fwd_addr(fwd_addr), .fwd_data(fwd_data), .halted(halted),
    .retire_count(retire_count)
  );

  typedef struct {
    logic        fv;
    logic [4:0]  fa;
    logic [31:0] fd;
    logic        hl;
    logic [31:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: architectural state only.
  logic [31:0] m_rf [32];
  logic        m_halted;
  logic [31:0] m_cnt;
  logic        m_fv;
  logic [4:0]  m_fa;
  logic [31:0] m_fd;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_rf[i] = '0;
    m_halted = 1'b0;
    m_cnt    = '0;
    m_fv     = 1'b0;
    m_fa     = '0;
    m_fd     = '0;
  endtask

  function automatic logic [180:0] mk_bus(input logic [31:0] d, input logic [4:0] a,
                                          input logic we, input logic [15:0] op);
    logic [191:0] junk;
    junk = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    junk[31:0]    = d;
    junk[68:64]   = a;
    junk[69]      = we;
    junk[175:160] = op;
    return junk[180:0];
  endfunction

  function automatic logic [31:0] exp_read(input logic [4:0] ra, input logic wr,
                                           input logic [4:0] wa, input logic [31:0] d);
    if (ra == 5'd0) return 32'd0;
`ifdef WB_BYPASS_EN
    if (wr && ra == wa) return d;
`endif
    return m_rf[ra];
  endfunction

  // Called at a falling edge; drives one cycle, returns at the next falling edge.
  task automatic step(input logic v, input logic [31:0] d, input logic [4:0] a,
                      input logic we, input logic [15:0] op, input logic res,
                      input logic [4:0] ra, input logic [4:0] rb);
    exp_t e;
    logic acc, wr;
    ex_valid = v;
    EX_WB    = mk_bus(d, a, we, op);
    resume   = res;
    rs_addr  = ra;
    rt_addr  = rb;
    acc = v && !m_halted && reset;
    wr  = acc && (op != HLT) && (op != NOP) && we && (a != 5'd0);
    #1;
    check("rs_data", rs_data, exp_read(ra, wr, a, d));
    check("rt_data", rt_data, exp_read(rb, wr, a, d));
    @(posedge clock);
    if (!reset) begin
      model_reset();
    end else begin
      if (wr) begin
        m_rf[a] = d;
        m_fa    = a;
        m_fd    = d;
      end
      m_fv = wr;
      if (acc) m_cnt = m_cnt + 32'd1;
      if (acc && op == HLT) m_halted = 1'b1;
      else if (m_halted && res) m_halted = 1'b0;
    end
    e.fv = m_fv; e.fa = m_fa; e.fd = m_fd; e.hl = m_halted; e.cnt = m_cnt;
    exp_q.push_back(e);
    @(negedge clock);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_fwd_valid"}, {31'd0, fwd_valid}, 32'd0);
    check({tag, "_fwd_addr"}, {27'd0, fwd_addr}, 32'd0);
    check({tag, "_fwd_data"}, fwd_data, 32'd0);
    check({tag, "_retire"}, retire_count, 32'd0);
    check({tag, "_halted"}, {31'd0, halted}, 32'd0);
    check({tag, "_rs_data"}, rs_data, 32'd0);
    check({tag, "_rt_data"}, rt_data, 32'd0);
  endtask

  // Monitor: compares registered outputs just after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("fwd_valid", {31'd0, fwd_valid}, {31'd0, e.fv});
        check("fwd_addr", {27'd0, fwd_addr}, {27'd0, e.fa});
        check("fwd_data", fwd_data, e.fd);
        check("halted", {31'd0, halted}, {31'd0, e.hl});
        check("wb_ready", {31'd0, wb_ready}, {31'd0, !e.hl});
        check("retire_count", retire_count, e.cnt);
      end
    end
  end

  initial begin
    logic [15:0] op;
    logic [4:0]  a;
    logic [31:0] d;
    reset    = 1'b0;
    ex_valid = 1'b0;
    resume   = 1'b0;
    EX_WB    = '0;
    rs_addr  = 5'd5;
    rt_addr  = 5'd9;
    model_reset();
    #1;
    check_reset_outputs("por");
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("wb_ready_after_reset", {31'd0, wb_ready}, 32'd1);
    @(negedge clock);

    for (int i = 0; i < 32; i++) step(1'b0, 0, 0, 1'b0, 16'h1, 1'b0, i[4:0], 5'(31 - i));

    // Basic write then read-back
    step(1'b1, 32'hDEADBEEF, 5'd5, 1'b1, 16'h1, 1'b0, 5'd0, 5'd0);
    step(1'b0, 0, 0, 1'b0, 16'h1, 1'b0, 5'd5, 5'd5);

    // Register 0 write discarded, then NOP
    step(1'b1, 32'h1234, 5'd0, 1'b1, 16'h1, 1'b0, 5'd0, 5'd0);
    step(1'b1, 32'h5555, 5'd9, 1'b1, NOP, 1'b0, 5'd0, 5'd9);
    step(1'b0, 0, 0, 1'b0, 16'h1, 1'b0, 5'd0, 5'd9);

    // HLT, stalled write to r3, resume, write commits
    step(1'b1, 0, 5'd1, 1'b1, HLT, 1'b0, 5'd3, 5'd1);
    for (int i = 0; i < 4; i++) step(1'b1, 32'h77, 5'd3, 1'b1, 16'h1, 1'b0, 5'd3, 5'd3);
    step(1'b1, 32'h77, 5'd3, 1'b1, 16'h1, 1'b1, 5'd3, 5'd3);
    step(1'b1, 32'h77, 5'd3, 1'b1, 16'h1, 1'b0, 5'd3, 5'd3);
    step(1'b0, 0, 0, 1'b0, 16'h1, 1'b0, 5'd3, 5'd3);

    // HLT and resume in the same cycle: HLT wins
    step(1'b1, 0, 0, 1'b0, HLT, 1'b1, 5'd0, 5'd0);
    step(1'b0, 0, 0, 1'b0, 16'h1, 1'b1, 5'd0, 5'd0);

    // Same-cycle read of a write
    step(1'b1, 32'hA5A5A5A5, 5'd7, 1'b1, 16'h2, 1'b0, 5'd7, 5'd7);
    step(1'b0, 0, 0, 1'b0, 16'h1, 1'b0, 5'd7, 5'd7);

    for (int i = 0; i < 1500; i++) begin
      case ($urandom_range(0, 15))
        0:       op = HLT;
        1, 2:    op = NOP;
        3:       op = 16'($urandom);
        default: op = 16'($urandom_range(0, 13));
      endcase
      a = 5'($urandom);
      d = $urandom;
      step($urandom_range(0, 3) != 0, d, a, $urandom_range(0, 4) != 0, op,
           $urandom_range(0, 2) == 0,
           ($urandom_range(0, 1) != 0) ? a : 5'($urandom), 5'($urandom));
    end

    // Leave RUN, write several registers, then reset between edges
    step(1'b0, 0, 0, 1'b0, 16'h1, 1'b1, 5'd0, 5'd0);
    for (int i = 1; i < 6; i++) step(1'b1, 32'hC0DE0000 + i, i[4:0], 1'b1, 16'h3, 1'b0, 5'd2, 5'd4);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    check_reset_outputs("async");
    @(negedge clock);
    step(1'b1, 0, 0, 1'b0, HLT, 1'b0, 5'd2, 5'd4);
    step(1'b1, 32'h99, 5'd6, 1'b1, 16'h1, 1'b0, 5'd6, 5'd4);
    reset = 1'b1;
    for (int i = 0; i < 32; i++) step(1'b0, 0, 0, 1'b0, 16'h1, 1'b0, i[4:0], 5'(31 - i));
    step(1'b1, 32'h0BADF00D, 5'd2, 1'b1, 16'h4, 1'b0, 5'd2, 5'd1);
    step(1'b0, 0, 0, 1'b0, 16'h1, 1'b0, 5'd2, 5'd1);

    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
